// File: rtl/ysyx_22041071_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041071_div_pkg
// Brief    : Shared types and constants for the iterative divider.
// Revision : 1.0
// ============================================================================
package ysyx_22041071_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int DIV_XLEN_MAX = 64;
    localparam int DIV_WORD_W   = 32;

    // Quotient pattern for x/0 before truncation to the operand width.
    localparam logic [DIV_XLEN_MAX-1:0] DIV_ZERO_QUOT = '1;

    function automatic int div_cnt_w(input int xlen);
        return $clog2(xlen);
    endfunction

    function automatic logic [DIV_XLEN_MAX-1:0] div_sext_word(input logic [DIV_WORD_W-1:0] w);
        return {{(DIV_XLEN_MAX-DIV_WORD_W){w[DIV_WORD_W-1]}}, w};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22041071_div_prep.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041071_div_prep
// Brief    : Operand conditioning: word select, magnitudes, signs, special cases.
// Revision : 1.0
// ============================================================================
module ysyx_22041071_div_prep
    import ysyx_22041071_div_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic            i_div_signed,
    input  logic            i_divw,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_word,
    output logic [XLEN-1:0] o_abs_dend,
    output logic [XLEN-1:0] o_abs_dsor,
    output logic            o_q_neg,
    output logic            o_r_neg,
    output logic            o_div_zero,
    output logic            o_ovf,
    output logic            o_small
);

    localparam logic [XLEN-1:0] c_wmask = XLEN'({WLEN{1'b1}});
    localparam logic [XLEN-1:0] c_min_x = XLEN'(1) << (XLEN - 1);
    localparam logic [XLEN-1:0] c_min_w = XLEN'(1) << (WLEN - 1);

    logic            w_word;
    logic [XLEN-1:0] w_mask;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_min;

    assign w_word = (XLEN == 64) && i_divw;
    assign w_mask = w_word ? c_wmask : '1;
    assign w_a    = i_dividend & w_mask;
    assign w_b    = i_divisor  & w_mask;
    assign w_sa   = i_div_signed & (w_word ? i_dividend[WLEN-1] : i_dividend[XLEN-1]);
    assign w_sb   = i_div_signed & (w_word ? i_divisor[WLEN-1]  : i_divisor[XLEN-1]);
    assign w_min  = w_word ? c_min_w : c_min_x;

    // Negation is done at full width and masked back, so the most-negative
    // value maps onto its own unsigned magnitude.
    assign o_abs_dend = (w_sa ? (XLEN'(0) - w_a) : w_a) & w_mask;
    assign o_abs_dsor = (w_sb ? (XLEN'(0) - w_b) : w_b) & w_mask;

    assign o_word     = w_word;
    assign o_q_neg    = w_sa ^ w_sb;
    assign o_r_neg    = w_sa;
    assign o_div_zero = (w_b == '0);
    assign o_ovf      = i_div_signed && (w_a == w_min) && (w_b == w_mask);
    assign o_small    = (o_abs_dend < o_abs_dsor);

endmodule
`default_nettype wire

// File: rtl/ysyx_22041071_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041071_div_iter
// Brief    : Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU + W forms).
//            Optional macro YSYX_22041071_DIV_EARLY_OUT_EN skips CALC for
//            x/0, signed overflow and |dividend| < |divisor|.
// Revision : 1.0
// ============================================================================
module ysyx_22041071_div_iter
    import ysyx_22041071_div_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            div_signed,
    input  logic            divw,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rema
);

    localparam int CNT_W = div_cnt_w(XLEN);

    localparam logic [CNT_W-1:0] c_last_x = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] c_last_w = CNT_W'(WLEN - 1);
    localparam logic [XLEN-1:0]  c_min_x  = XLEN'(1) << (XLEN - 1);
    localparam logic [XLEN-1:0]  c_min_w  = XLEN'(1) << (WLEN - 1);
`ifdef YSYX_22041071_DIV_EARLY_OUT_EN
    localparam logic             c_early_en = 1'b1;
`else
    localparam logic             c_early_en = 1'b0;
`endif

    div_state_e      r_state;
    div_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_dend;
    logic [XLEN-1:0] r_dsor;
    logic [XLEN-1:0] r_rem;
    logic            r_word;
    logic            r_q_neg;
    logic            r_r_neg;
    logic            r_zero;
    logic            r_ovf;

    logic            w_p_word;
    logic [XLEN-1:0] w_p_abs_a;
    logic [XLEN-1:0] w_p_abs_b;
    logic            w_p_q_neg;
    logic            w_p_r_neg;
    logic            w_p_zero;
    logic            w_p_ovf;
    logic            w_p_small;

    logic            w_accept;
    logic            w_early;
    logic            w_last;

    ysyx_22041071_div_prep #(
        .XLEN (XLEN),
        .WLEN (WLEN)
    ) u_prep (
        .i_div_signed (div_signed),
        .i_divw       (divw),
        .i_dividend   (dividend),
        .i_divisor    (divisor),
        .o_word       (w_p_word),
        .o_abs_dend   (w_p_abs_a),
        .o_abs_dsor   (w_p_abs_b),
        .o_q_neg      (w_p_q_neg),
        .o_r_neg      (w_p_r_neg),
        .o_div_zero   (w_p_zero),
        .o_ovf        (w_p_ovf),
        .o_small      (w_p_small)
    );

    assign w_early = c_early_en & (w_p_zero | w_p_ovf | w_p_small);

    // One restoring step: quotient bits shift into the vacated low end of r_dend.
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_qbit;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_dend_nxt;

    assign w_shift    = {r_rem, r_dend[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, r_dsor};
    assign w_qbit     = ~w_diff[XLEN];
    assign w_rem_nxt  = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_dend_nxt = {r_dend[XLEN-2:0], w_qbit};
    assign w_last     = (r_cnt == (r_word ? c_last_w : c_last_x));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_early ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (w_last) begin
                    w_state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = DIV_IDLE;
                end
            end
            default: w_state_nxt = DIV_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = DIV_IDLE;
        end
    end

    // Result mux: in IDLE it serves the early-out path straight from the
    // prep logic, otherwise the final CALC step with latched flags.
    logic            w_src_idle;
    logic            w_f_word;
    logic            w_f_q_neg;
    logic            w_f_r_neg;
    logic            w_f_zero;
    logic            w_f_ovf;
    logic [XLEN-1:0] w_q_raw;
    logic [XLEN-1:0] w_r_raw;
    logic [XLEN-1:0] w_fix_q;
    logic [XLEN-1:0] w_fix_r;
    logic [XLEN-1:0] w_res_q;
    logic [XLEN-1:0] w_res_r;

    assign w_src_idle = (r_state == DIV_IDLE);

    always_comb begin
        w_f_word  = w_src_idle ? w_p_word  : r_word;
        w_f_q_neg = w_src_idle ? w_p_q_neg : r_q_neg;
        w_f_r_neg = w_src_idle ? w_p_r_neg : r_r_neg;
        w_f_zero  = w_src_idle ? w_p_zero  : r_zero;
        w_f_ovf   = w_src_idle ? w_p_ovf   : r_ovf;
        w_q_raw   = w_src_idle ? '0        : w_dend_nxt;
        w_r_raw   = w_src_idle ? w_p_abs_a : w_rem_nxt;

        w_fix_q = w_f_q_neg ? (XLEN'(0) - w_q_raw) : w_q_raw;
        w_fix_r = w_f_r_neg ? (XLEN'(0) - w_r_raw) : w_r_raw;
        if (w_f_zero) begin
            w_fix_q = XLEN'(DIV_ZERO_QUOT);
        end
        if (w_f_ovf) begin
            w_fix_q = w_f_word ? c_min_w : c_min_x;
            w_fix_r = '0;
        end

        w_res_q = w_f_word ? XLEN'(div_sext_word(w_fix_q[DIV_WORD_W-1:0])) : w_fix_q;
        w_res_r = w_f_word ? XLEN'(div_sext_word(w_fix_r[DIV_WORD_W-1:0])) : w_fix_r;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_dend  <= '0;
            r_dsor  <= '0;
            r_rem   <= '0;
            r_word  <= 1'b0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            quot    <= '0;
            rema    <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            // Word operands are left-aligned so the MSB-first walk starts at bit 31.
            r_dend  <= w_p_word ? (w_p_abs_a << (XLEN - WLEN)) : w_p_abs_a;
            r_dsor  <= w_p_abs_b;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_word  <= w_p_word;
            r_q_neg <= w_p_q_neg;
            r_r_neg <= w_p_r_neg;
            r_zero  <= w_p_zero;
            r_ovf   <= w_p_ovf;
            if (w_early) begin
                quot <= w_res_q;
                rema <= w_res_r;
            end
        end else if (r_state == DIV_CALC) begin
            r_dend <= w_dend_nxt;
            r_rem  <= w_rem_nxt;
            if (w_last) begin
                r_cnt <= '0;
                quot  <= w_res_q;
                rema  <= w_res_r;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041071_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22041071_div_iter
// Brief    : Scoreboard bench for the iterative divider (XLEN=64).
// Revision : 1.0
// ============================================================================
module tb_ysyx_22041071_div_iter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        div_signed;
    logic        divw;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quot;
    logic [63:0] rema;

`ifdef YSYX_22041071_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    ysyx_22041071_div_iter #(.XLEN(64), .WLEN(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .div_signed (div_signed),
        .divw       (divw),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quot       (quot),
        .rema       (rema)
    );

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk   = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          or_mode = 1;
    bit          seen    = 1'b0;
    logic [63:0] held_q;
    logic [63:0] held_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    function automatic logic [63:0] mag(input logic [63:0] x, input bit s);
        return (s && x[63]) ? (64'd0 - x) : x;
    endfunction

    // Reference: RISC-V M-extension semantics using native arithmetic.
    function automatic exp_t model(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [31:0] a32, b32, q32, r32;
        logic [63:0] ax, bx;
        bit          early;
        early = 1'b0;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            ax  = s ? {{32{a32[31]}}, a32} : {32'h0, a32};
            bx  = s ? {{32{b32[31]}}, b32} : {32'h0, b32};
            if (b32 == 32'h0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32; early = 1'b1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'h0; early = 1'b1;
            end else begin
                if (s) begin
                    q32 = $signed(a32) / $signed(b32);
                    r32 = $signed(a32) % $signed(b32);
                end else begin
                    q32 = a32 / b32;
                    r32 = a32 % b32;
                end
                early = mag(ax, s) < mag(bx, s);
            end
            e.q = {{32{q32[31]}}, q32};
            e.r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'h0) begin
                e.q = '1; e.r = a; early = 1'b1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                e.q = a; e.r = 64'h0; early = 1'b1;
            end else begin
                if (s) begin
                    e.q = $signed(a) / $signed(b);
                    e.r = $signed(a) % $signed(b);
                end else begin
                    e.q = a / b;
                    e.r = a % b;
                end
                early = mag(a, s) < mag(b, s);
            end
        end
        e.lat = (EARLY && early) ? 1 : (w ? 33 : 65);
        e.acc = 0;
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (or_mode == 0) out_ready = ($urandom_range(3) != 0);
    end

    // Monitor: pops on each new result, then checks it is held while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            if (!seen) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: got out_valid 1 quot %h expected no result", quot);
                end else begin
                    e = sb.pop_front();
                    check("quot", quot, e.q);
                    check("rema", rema, e.r);
                    check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                end
                held_q = quot;
                held_r = rema;
            end else begin
                check("hold_quot", quot, held_q);
                check("hold_rema", rema, held_r);
            end
            seen = !out_ready;
        end else begin
            seen = 1'b0;
        end
    end

    task automatic issue(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b, input bit chk_en);
        exp_t e;
        int   t;
        e = model(s, w, a, b);
        @(posedge clk); #1;
        div_signed = s; divw = w; dividend = a; divisor = b; in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) begin
            n_chk++;
            $display("FAIL accept_timeout: got in_ready %b expected 1", in_ready);
        end else begin
            e.acc = cyc + 1;
            if (chk_en) sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || in_ready !== 1'b1) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        bit          s, w, any;
        int          kind, t;
        logic [63:0] a, b;

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        div_signed = 1'b0; divw = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quot", quot, 64'd0);
        check("rst_rema", rema, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        issue(1'b0, 1'b0, 64'd100, 64'd7, 1'b1);
        issue(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
        issue(1'b1, 1'b0, 64'h1234, 64'd0, 1'b1);
        issue(1'b1, 1'b1, 64'h8000_0000, 64'd0, 1'b1);
        issue(1'b1, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b1);
        issue(1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1);
        issue(1'b1, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFF6, 1'b1);
        drain();

        @(negedge clk) or_mode = 0;
        for (int i = 0; i < 40; i++) begin
            s    = 1'($urandom_range(1));
            w    = 1'($urandom_range(1));
            kind = $urandom_range(5);
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            case (kind)
                1: begin
                    b = 64'($urandom_range(15) + 1);
                    if (s && $urandom_range(1) == 1) b = 64'd0 - b;
                end
                2: b = 64'd0;
                3: begin
                    s = 1'b1;
                    a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
                    b = '1;
                end
                4: a = 64'($urandom_range(100));
                5: a = a >> $urandom_range(63);
                default: ;
            endcase
            issue(s, w, a, b, 1'b1);
        end
        drain();

        // Backpressure: hold the result for ten cycles.
        @(negedge clk) or_mode = 1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(1'b0, 1'b0, 64'd1000, 64'd3, 1'b1);
        t = 0;
        while (out_valid !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_reach_done", 64'(out_valid), 64'd1);
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);

        // Flush while the counter sits at 20.
        issue(1'b1, 1'b0, 64'd0 - 64'd12345, 64'd77, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle_ready", 64'(in_ready), 64'd1);
        check("flush_idle_valid", 64'(out_valid), 64'd0);
        any = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            any = any | (out_valid === 1'b1);
        end
        check("flush_no_out", 64'(any), 64'd0);

        in_valid = 1'b1; flush = 1'b1; dividend = 64'd50; divisor = 64'd5;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", 64'(in_ready), 64'd1);

        // Asynchronous reset in the middle of CALC.
        issue(1'b0, 1'b0, {$urandom, $urandom}, 64'd5, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_quot", quot, 64'd0);
        check("arst_rema", rema, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        issue(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
        issue(1'b0, 1'b0, 64'd100, 64'd7, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
